// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier-sharing arbiter.
package mult_pkg;

    localparam int DEF_SIZE = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } mult_state_t;

endpackage

// File: rtl/multiplier.sv
// Unsigned combinational multiplier, SIZE x SIZE -> 2*SIZE.
module multiplier #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] p
);

    // Zero-extend both operands so the product is computed at full width.
    assign p = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr+1 and wraps mod NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic           found;
    int             idx;
    logic [IDW-1:0] idx_v;

    // First set request after the last winner takes the grant.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        idx_v    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(ptr) + k) % NREQ;
            idx_v = IDW'(idx);
            if (!found && req[idx_v]) begin
                found        = 1'b1;
                grant[idx_v] = 1'b1;
                grant_id     = idx_v;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Shares a single multiplier among NREQ requesters; one operation in flight.
//
// state | meaning
// IDLE  | arbitrate, accept one operand pair
// EXEC  | captured operands drive the multiplier
// RESP  | product held on the response channel until taken
module mult_share_arb
    import mult_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int NREQ = DEF_NREQ,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*SIZE-1:0]    rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    mult_state_t        state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id_q;
    logic [SIZE-1:0]    op_a;
    logic [SIZE-1:0]    op_b;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic [SIZE-1:0]    sel_a;
    logic [SIZE-1:0]    sel_b;
    logic [2*SIZE-1:0]  product;
    logic               accept;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    multiplier #(
        .SIZE (SIZE)
    ) u_mult (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Grants are only offered in IDLE and never while reset is asserted.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_a = req_a[i*SIZE +: SIZE];
                sel_b = req_b[i*SIZE +: SIZE];
            end
        end
    end

    // Sequencer: capture operands, register the product, hold until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            id_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        id_q  <= grant_id;
                        ptr   <= grant_id;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= product;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: vector table plus multi-cycle sequences.
module tb_mult_share_arb;

    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*SIZE-1:0]    rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [5];

    mult_share_arb #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i] = 1'b1;
        req_a[i*SIZE +: SIZE] = a;
        req_b[i*SIZE +: SIZE] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        settle();
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [7:0]  rr_a [4];
        logic [7:0]  rr_b [4];
        logic [15:0] rr_p [4];
        int exp_id;

        vecs[0] = '{id: 2, a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{id: 0, a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2] = '{id: 1, a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{id: 3, a: 8'd1,   b: 8'd255, p: 16'd255};
        vecs[4] = '{id: 2, a: 8'd100, b: 8'd3,   p: 16'd300};

        rr_a = '{8'd3, 8'd5, 8'd7, 8'd9};
        rr_b = '{8'd4, 8'd6, 8'd8, 8'd10};
        rr_p = '{16'd12, 16'd30, 16'd56, 16'd90};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        do_reset();

        // Single-requester vectors: accept, EXEC, RESP, transfer.
        for (int v = 0; v < 5; v++) begin
            req_valid = '0;
            set_req(vecs[v].id, vecs[v].a, vecs[v].b);
            settle();
            chk("vec_grant", 32'(req_ready), 32'(1) << vecs[v].id);
            tick();
            chk("vec_exec_busy",  32'(busy),      32'h1);
            chk("vec_exec_ready", 32'(req_ready), 32'h0);
            chk("vec_exec_valid", 32'(rsp_valid), 32'h0);
            tick();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("vec_rsp_data",  32'(rsp_data),  32'(vecs[v].p));
            chk("vec_rsp_id",    32'(rsp_id),    32'(vecs[v].id));
            req_valid = '0;
            tick();
            chk("vec_done_valid", 32'(rsp_valid), 32'h0);
            chk("vec_done_busy",  32'(busy),      32'h0);
        end

        // Round robin with all four requesters held valid.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i]);
        for (int n = 0; n < 5; n++) begin
            exp_id = n % 4;
            settle();
            chk("rr_grant", 32'(req_ready), 32'(1) << exp_id);
            tick();
            chk("rr_exec_ready", 32'(req_ready), 32'h0);
            tick();
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rr_rsp_id",    32'(rsp_id),    32'(exp_id));
            chk("rr_rsp_data",  32'(rsp_data),  32'(rr_p[exp_id]));
            if (n == 4) req_valid = '0;
            tick();
        end
        chk("rr_end_valid", 32'(rsp_valid), 32'h0);

        // Response back-pressure for five cycles.
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(1, 8'd12, 8'd12);
        settle();
        chk("hold_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        set_req(3, 8'd2, 8'd2);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_data",  32'(rsp_data),  32'd144);
            chk("hold_id",    32'(rsp_id),    32'h1);
            chk("hold_ready", 32'(req_ready), 32'h0);
            chk("hold_busy",  32'(busy),      32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        settle();
        chk("hold_last_valid", 32'(rsp_valid), 32'h1);
        tick();
        chk("hold_xfer_valid", 32'(rsp_valid), 32'h0);
        chk("hold_xfer_busy",  32'(busy),      32'h0);

        // Reset asserted during EXEC discards the operation.
        set_req(2, 8'd7, 8'd7);
        settle();
        tick();
        chk("abort_exec_busy", 32'(busy), 32'h1);
        rst_n     = 1'b0;
        req_valid = '0;
        set_req(0, 8'd1, 8'd1);
        set_req(3, 8'd2, 8'd2);
        settle();
        chk("abort_ready_rst", 32'(req_ready), 32'h0);
        tick();
        chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort_rsp_data",  32'(rsp_data),  32'h0);
        chk("abort_rsp_id",    32'(rsp_id),    32'h0);
        chk("abort_busy",      32'(busy),      32'h0);
        rst_n = 1'b1;
        settle();
        chk("abort_next_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("abort_rsp_id0",   32'(rsp_id),   32'h0);
        chk("abort_rsp_data1", 32'(rsp_data), 32'h1);
        tick();
        chk("abort_then_3", 32'(req_ready), 32'h8);
        req_valid = '0;
        tick();

        // Requester 1 pulses valid while requester 0 is being served.
        set_req(0, 8'd6, 8'd7);
        settle();
        chk("drop_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 8'd9, 8'd9);
        settle();
        chk("drop_exec_ready", 32'(req_ready), 32'h0);
        tick();
        req_valid[1] = 1'b0;
        chk("drop_rsp_id",   32'(rsp_id),   32'h0);
        chk("drop_rsp_data", 32'(rsp_data), 32'd42);
        tick();
        chk("drop_after_valid", 32'(rsp_valid), 32'h0);
        chk("drop_idle_ready",  32'(req_ready), 32'h0);
        tick();
        tick();
        chk("drop_no_rsp",  32'(rsp_valid), 32'h0);
        chk("drop_no_busy", 32'(busy),      32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
